// File: rtl/mem_burst_arbiter.sv
// Multi-channel arbiter plus byte-serial burst engine for block fills, writebacks and MMIO accesses.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest-index channel wins.
module mem_burst_arbiter #(
    parameter int CHANNELS    = 2,
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
    input  logic                             clkIn,
    input  logic                             resetIn,
    input  logic                             clearIn,
    input  logic [CHANNELS-1:0]              reqValid,
    input  logic [CHANNELS-1:0]              reqWrite,
    input  logic [CHANNELS-1:0]              reqSingle,
    input  logic [2*CHANNELS-1:0]            reqSize,
    input  logic [32*CHANNELS-1:0]           reqAddr,
    input  logic [8*BLOCK_SIZE*CHANNELS-1:0] reqData,
    output logic [CHANNELS-1:0]              reqReady,
    output logic [CHANNELS-1:0]              respValid,
    output logic [8*BLOCK_SIZE-1:0]          respData,
    input  logic [7:0]                       memIn,
    output logic [31:0]                      memAddr,
    output logic [7:0]                       memOut,
    output logic                             memWrite
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DBYTES = (BLOCK_SIZE > 4) ? BLOCK_SIZE : 4;
    localparam int DW     = 8 * DBYTES;
    localparam int BW     = 8 * BLOCK_SIZE;
    localparam int CNT_W  = $clog2(DBYTES) + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   win, owner;
    logic               grant;
    logic               sel_write, sel_single;
    logic [1:0]         sel_size;
    logic [31:0]        sel_addr, sel_base, base;
    logic [BW-1:0]      sel_data;
    logic [CNT_W-1:0]   sel_len, len, count, count_nxt, cap_idx;
    logic               is_write;
    logic [DW-1:0]      wdata, rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   last;
`endif

    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(last) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!found && reqValid[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
`else
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (reqValid[i]) win = IDX_W'(i);
        end
`endif
    end

    always_comb begin
        sel_write  = 1'b0;
        sel_single = 1'b0;
        sel_size   = 2'b00;
        sel_addr   = '0;
        sel_data   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (IDX_W'(i) == win) begin
                sel_write  = reqWrite[i];
                sel_single = reqSingle[i];
                sel_size   = reqSize[2*i +: 2];
                sel_addr   = reqAddr[32*i +: 32];
                sel_data   = reqData[BW*i +: BW];
            end
        end
        sel_base = sel_single ? sel_addr : (sel_addr & ~(32'(BLOCK_SIZE) - 32'd1));
        if (!sel_single)            sel_len = CNT_W'(BLOCK_SIZE);
        else if (sel_size == 2'b00) sel_len = CNT_W'(1);
        else if (sel_size == 2'b01) sel_len = CNT_W'(2);
        else                        sel_len = CNT_W'(4);
    end

    assign grant     = (state == IDLE) && !clearIn && (|reqValid);
    assign count_nxt = count + CNT_W'(1);
    assign cap_idx   = count - CNT_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = sel_write ? WRITE : READ;
            READ:    if (clearIn) state_nxt = IDLE;
                     else if (count == len) state_nxt = DONE;
            WRITE:   if (count == len - CNT_W'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) state <= IDLE;
        else          state <= state_nxt;
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn)   last <= IDX_W'(CHANNELS - 1);
        else if (grant) last <= win;
    end
`endif

    // Byte i is addressed in burst cycle i; the RAM returns it one cycle later.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            owner    <= '0;
            is_write <= 1'b0;
            base     <= '0;
            len      <= '0;
            wdata    <= '0;
            rdata    <= '0;
            count    <= '0;
            reqReady <= '0;
            memAddr  <= '0;
            memOut   <= '0;
            memWrite <= 1'b0;
        end else begin
            reqReady <= '0;
            case (state)
                IDLE: if (grant) begin
                    owner    <= win;
                    is_write <= sel_write;
                    base     <= sel_base;
                    len      <= sel_len;
                    wdata    <= DW'(sel_data);
                    count    <= '0;
                    reqReady <= CHANNELS'(1) << win;
                    memAddr  <= sel_base;
                    if (sel_write) begin
                        memOut   <= sel_data[7:0];
                        memWrite <= 1'b1;
                    end
                end
                READ: if (!clearIn) begin
                    if (count == CNT_W'(1))
                        rdata <= {{(DW-8){1'b0}}, memIn};
                    else if (count != '0)
                        rdata[{cap_idx, 3'b000} +: 8] <= memIn;
                    if (count_nxt < len) memAddr <= base + 32'(count_nxt);
                    count <= count_nxt;
                end
                WRITE: begin
                    if (count_nxt < len) begin
                        memAddr <= base + 32'(count_nxt);
                        memOut  <= wdata[{count_nxt, 3'b000} +: 8];
                        count   <= count_nxt;
                    end else begin
                        memWrite <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A flush landing on the completion cycle of a read discards it; writes always complete.
    assign respValid = ((state == DONE) && (is_write || !clearIn)) ? (CHANNELS'(1) << owner) : '0;
    assign respData  = rdata[BW-1:0];

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Multi-channel arbiter and burst engine between the cache/load-store clients and the byte-wide RAM port. Accepts per-channel block-fill, block-writeback and uncached (MMIO) byte/half/word requests; serialises each into byte transfers and returns one assembled response. Generalises the single icache/dcache fill path to N channels and a configurable block size.

## Interface
Parameters:
- CHANNELS, 2: number of requesting clients (1..8).
- BLOCK_WIDTH, 4: log2 of block size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH: bytes per block transfer.

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  asynchronous, active-low reset.
- clearIn  input  1  misprediction flush; aborts read traffic.
- reqValid  input  CHANNELS  request present; held with fields stable until reqReady.
- reqWrite  input  CHANNELS  1 = write, 0 = read.
- reqSingle  input  CHANNELS  1 = uncached single access, 0 = block.
- reqSize  input  2*CHANNELS  single size: 00 byte, 01 half, 10/11 word.
- reqAddr  input  32*CHANNELS  byte address; block requests ignore low BLOCK_WIDTH bits.
- reqData  input  8*BLOCK_SIZE*CHANNELS  write data; single uses low 32 bits, byte 0 at [7:0].
- reqReady  output  CHANNELS  one-cycle accept pulse, one-hot.
- respValid  output  CHANNELS  one-cycle completion pulse, one-hot.
- respData  output  8*BLOCK_SIZE  read data; single zero-extended in [31:0].
- memIn  input  8  RAM read byte.
- memAddr  output  32  RAM byte address (registered).
- memOut  output  8  RAM write byte (registered).
- memWrite  output  1  1 = write cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if clearIn low and any reqValid, pick winner, latch its fields, pulse reqReady[winner], enter READ/WRITE with count = 0. Transfer length N = BLOCK_SIZE for block, 1/2/4 for single.
- Block base address = reqAddr with low BLOCK_WIDTH bits zeroed; single uses reqAddr as-is, no alignment requirement, byte i at reqAddr+i (32-bit wrap).
- READ: drive address of byte i in cycle i; memIn in cycle i+1 is byte i, stored at respData[8i+7:8i]. After byte N-1 captured -> DONE.
- WRITE: cycle i drives memAddr = base+i, memOut = byte i, memWrite = 1; after byte N-1 -> DONE.
- DONE: memWrite = 0, respValid[winner] = 1 for one cycle; -> IDLE.
- clearIn: in READ -> IDLE next edge, no respValid, respData unspecified; in DONE of a read -> respValid suppressed; in IDLE -> no grant; in WRITE/DONE of a write -> ignored (writes never torn).
- Winner channel stays latched; reqValid of other channels stays pending, never dropped.

## Timing
- Reset values: memAddr 0, memOut 0, memWrite 0, reqReady 0, respValid 0, respData 0, state IDLE, round-robin pointer = CHANNELS-1 (channel 0 served first).
- Let E0 be the grant edge. reqReady high in cycle 0 after E0; memAddr = byte 0 address in cycle 0.
- Read: respValid in cycle N+1 (block of 16: cycle 17). Write: respValid in cycle N, memWrite high cycles 0..N-1 only.
- One IDLE cycle follows every DONE; next grant at that cycle's ending edge. Minimum request-to-request spacing: read N+3 cycles, write N+2.
- respData held stable from respValid until next read captures.
- Reset assertion mid-burst: immediate return to reset values; no response issued.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: winner = first valid channel after the last granted one (wrap at CHANNELS-1), pointer updated on grant.
- Undefined: fixed priority, lowest-index valid channel wins; pointer logic absent.

## Test plan
- Block read, ch0, addr 0x1234, RAM byte k = k: reqReady cycle 0, memAddr 0x1230..0x123F cycles 0..15, respValid[0] cycle 17, respData byte i = 0x30+i.
- Block write, ch1, reqData bytes 0xA0..0xAF to 0x2000: memWrite high exactly 16 cycles, addresses 0x2000..0x200F, respValid[1] cycle 16, RAM contents match.
- Single half read at 0x30001 (bytes 0x11,0x22): 2 address cycles, respValid cycle 3, respData = 0x00002211.
- ch0 and ch1 valid continuously, round-robin built: grants 0,1,0,1; without macro: grants 0,0,0 while ch0 valid.
- clearIn pulse in cycle 5 of a block read: back to IDLE, no respValid; same pulse during block write: write completes, respValid issued.
- resetIn low during cycle 7 of a write: memWrite 0 immediately, all outputs reset values, next request serviced normally.
